// File: rtl/uart_pkg.sv
// Shared types for the framed UART transmitter: parity mode, FSM states, bit-period helper.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_t;

   function automatic int bit_cycles(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period down-counter; tick pulses for one cycle when the count reaches zero.
module uart_baud_gen #(
   parameter int BIT_CYC = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic en,
   output logic tick
);

   localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(BIT_CYC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Reload on zero so each period is exactly BIT_CYC cycles and never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = RELOAD;
      end else if (en) begin
         cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
      end
   end

   assign tick = en && !restart && (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter (start, LSB-first data, optional parity, 1-2 stop bits).
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_framed
   import uart_pkg::*;
#(
   parameter int      CLK_FREQ  = 100_000_000,
   parameter int      BAUD      = 115200,
   parameter int      DATA_BITS = 8,
   parameter int      STOP_BITS = 1,
   parameter parity_t PARITY    = PAR_NONE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_framed: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_framed: STOP_BITS must be 1..2");
   end
   if (BIT_CYC < 2) begin : g_bad_bit_cyc
      $error("uart_tx_framed: CLK_FREQ/BAUD must be at least 2");
   end
`ifdef UART_TX_PARITY_EN
   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
      $error("uart_tx_framed: PARITY must be PAR_NONE, PAR_EVEN or PAR_ODD");
   end
   localparam logic PAR_EN  = (PARITY != PAR_NONE);
   localparam logic PAR_INV = (PARITY == PAR_ODD);
`else
   if (PARITY != PAR_NONE) begin : g_parity_not_built
      $error("uart_tx_framed: parity requested but UART_TX_PARITY_EN is not defined");
   end
`endif

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [3:0]           bit_idx_q, bit_idx_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif
   logic                 restart;
   logic                 tick;

   uart_baud_gen #(
      .BIT_CYC(BIT_CYC)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .en     (state_q != IDLE),
      .tick   (tick)
   );

   // Line value for the next bit is decided on the tick ending the current bit.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      restart   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (valid) begin
               state_d   = START;
               shreg_d   = data;
               bit_idx_d = '0;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               restart   = 1'b1;
`ifdef UART_TX_PARITY_EN
               par_d     = (^data) ^ PAR_INV;
`endif
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               tx_d    = shreg_q[0];
               shreg_d = shreg_q >> 1;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  if (PAR_EN) begin
                     state_d = PAR;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  tx_d      = shreg_q[0];
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PAR: begin
            if (tick) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (bit_idx_q == 4'(STOP_BITS - 1)) begin
                  state_d   = IDLE;
                  bit_idx_d = '0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  tx_d      = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign ready = (state_q == IDLE);
   assign tx    = tx_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
- REQ-001: Parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
- REQ-002: Parameter BAUD, default 115200, line rate in bit/s.
- REQ-003: Parameter DATA_BITS, default 8, payload bits per frame, legal 5..9.
- REQ-004: Parameter STOP_BITS, default 1, stop bits per frame, legal 1..2.
- REQ-005: Parameter PARITY, default PAR_NONE, a uart_pkg::parity_t value: PAR_NONE, PAR_EVEN or PAR_ODD.
- REQ-006: Port clk, input, 1 bit, the single clock.
- REQ-007: Port rst, input, 1 bit, asynchronous active-high reset.
- REQ-008: Port data, input, DATA_BITS bits, payload, sampled on acceptance.
- REQ-009: Port valid, input, 1 bit, payload offered.
- REQ-010: Port ready, output, 1 bit, the block can accept a payload this cycle.
- REQ-011: Port tx, output, 1 bit, serial line, idle high.
- REQ-012: Port busy, output, 1 bit, a frame is in progress.
- REQ-013: Port done, output, 1 bit, one-cycle pulse at frame completion.

Function
- REQ-014: BIT_CYC = CLK_FREQ/BAUD (integer division); every line bit shall last exactly BIT_CYC cycles.
- REQ-015: Elaboration shall fail with $error if DATA_BITS, STOP_BITS or PARITY is illegal, or if BIT_CYC < 2.
- REQ-016: FSM states IDLE, START, DATA, PAR, STOP; transitions: IDLE->START on acceptance; START->DATA; DATA->PAR or STOP after DATA_BITS bits; PAR->STOP; STOP->IDLE after STOP_BITS bits.
- REQ-017: ready shall be 1 exactly when state is IDLE; acceptance is valid&&ready at a rising edge.
- REQ-018: On acceptance, data shall be latched, and tx shall be driven 0 (start bit) and busy driven 1 from the next cycle.
- REQ-019: Data bits shall be sent LSB first.
- REQ-020: PAR_EVEN parity bit = XOR of payload; PAR_ODD = its inverse; PAR_NONE skips the PAR state.
- REQ-021: Stop bits shall be 1 for STOP_BITS*BIT_CYC cycles.
- REQ-022: Frame length shall be (1+DATA_BITS+P+STOP_BITS)*BIT_CYC cycles, with P = 1 if parity is enabled, else 0.
- REQ-023: done shall pulse in the cycle the FSM returns to IDLE; busy shall fall in that same cycle.
- REQ-024: IDLE shall last at least one cycle between frames, so back-to-back frames are separated by exactly one idle-high cycle.
- REQ-025: valid and data changes while ready=0 shall be ignored, and the frame shall not be altered.
- REQ-026: The baud counter shall count down from BIT_CYC-1 to 0 with no wrap beyond its range; its width shall be $clog2(BIT_CYC).

Reset
- REQ-027: Reset values: tx=1, busy=0, done=0, ready=1, state=IDLE, counters=0.
- REQ-028: Reset asserted mid-frame shall immediately force tx=1 with no partial stop bit, and the frame is discarded.

Configuration
- REQ-029: With UART_TX_PARITY_EN defined, the PARITY parameter and the PAR state shall be compiled in.
- REQ-030: Without UART_TX_PARITY_EN, no parity logic shall exist, frames shall never contain a parity bit, and PARITY other than PAR_NONE shall be an elaboration $error.

Structure
- REQ-031: Package uart_pkg shall hold parity_t, the tx FSM state enum, and the function for the BIT_CYC computation.
- REQ-032: Sub-module uart_baud_gen shall provide a restartable BIT_CYC down-counter with a one-cycle tick output; uart_tx_framed shall instantiate it.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, BIT_CYC=10)
- REQ-033: 8N1, data=0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 10 cycles; done at cycle 100 after acceptance.
- REQ-034: 8E1, data=0x07 -> parity bit 1; 8O1, data=0x07 -> parity bit 0; frame 110 cycles.
- REQ-035: 5N2, data=0x1F -> bits 0,1,1,1,1,1,1,1; frame 80 cycles; 6th payload bit never sent.
- REQ-036: valid held high for 3 frames of 0x55 -> exactly one idle-high cycle between frames; data changes mid-frame are not transmitted.
- REQ-037: rst asserted at cycle 37 of a frame -> tx=1 and busy=0 within the same cycle; no done pulse.
- REQ-038: Build without UART_TX_PARITY_EN and PARITY=PAR_EVEN -> elaboration error.
